// File: rtl/vdp_cpu_port_pkg.sv
// Shared definitions for the VDP CPU port: port select codes, status bit
// layout, VRAM op encodings and FSM states.
package vdp_cpu_port_pkg;

    localparam logic PORT_DATA = 1'b0;   // 0x98
    localparam logic PORT_CTRL = 1'b1;   // 0x99

    // Status byte bit positions
    localparam int ST_INT_BIT  = 7;
    localparam int ST_5S_BIT   = 6;
    localparam int ST_COLL_BIT = 5;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } vram_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } fsm_state_e;

    // One queued VRAM operation. The address is not stored: it is taken
    // from the address register at the moment the op is issued.
    typedef struct packed {
        vram_op_e   op;
        logic [7:0] data;
    } vram_cmd_t;

    // Build the status byte seen on a control-port read.
    function automatic logic [7:0] status_byte(input logic       int_flag,
                                               input logic       fifth,
                                               input logic       coll,
                                               input logic [4:0] spr);
        logic [7:0] s;
        s              = 8'h00;
        s[ST_INT_BIT]  = int_flag;
        s[ST_5S_BIT]   = fifth;
        s[ST_COLL_BIT] = coll;
        s[4:0]         = fifth ? spr : 5'h1F;
        return s;
    endfunction

endpackage

// File: rtl/vdp_cpu_port_if.sv
// VRAM request/ack bus between the CPU port sequencer and the video block's
// VRAM arbiter. master = CPU port, slave = arbiter.
interface vdp_cpu_port_if #(
    parameter int ADDR_BITS = 14
);
    logic                 req;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           wdata;
    logic [7:0]           rdata;
    logic                 ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style VDP CPU-side sequencer: control/data port decode, address and
// register latch, register file, status flags, read-ahead buffer and a
// single-outstanding VRAM request engine with a one-entry pending slot.
module vdp_cpu_port
    import vdp_cpu_port_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int NUM_REGS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_ena,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_sel,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [8*NUM_REGS-1:0] regs,
    input  logic                  set_int,
    input  logic                  set_coll,
    input  logic                  fifth_sprite,
    input  logic [4:0]            sprite5,
    output logic                  n_int,
    vdp_cpu_port_if.master        vram,
    output logic                  busy,
    output logic                  overflow
);

    localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    fsm_state_e                    state, state_n;
    logic [ADDR_BITS-1:0]          addr, addr_n;
    logic                          toggle;
    logic [7:0]                    first_byte;
    logic [NUM_REGS-1:0][7:0]      reg_file;
    logic [7:0]                    rd_buf;
    logic                          int_flag, coll_flag, stat_rd_d;

    logic                          req_q, we_q;
    logic [ADDR_BITS-1:0]          addr_q;
    logic [7:0]                    wdata_q;
    logic                          pend_valid;
    vram_cmd_t                     pend_cmd;

    // Decoded strobes for this clk_ena edge
    logic wr_stb, rd_stb, ctrl_wr, data_wr, data_rd, stat_rd;
    logic ctrl_second, addr_load, reg_load;
    logic new_valid;
    vram_cmd_t new_cmd, issue_cmd;
    logic issue, pend_set, pend_clr, drop, ack_done;

    assign wr_stb      = clk_ena & io_wr;
    assign rd_stb      = clk_ena & io_rd;
    assign ctrl_wr     = wr_stb & (port_sel == PORT_CTRL);
    assign data_wr     = wr_stb & (port_sel == PORT_DATA);
    assign data_rd     = rd_stb & (port_sel == PORT_DATA);
    assign stat_rd     = rd_stb & (port_sel == PORT_CTRL);
    assign ctrl_second = ctrl_wr & toggle;
    assign addr_load   = ctrl_second & ~din[7];
    assign reg_load    = ctrl_second & din[7] & (32'(din[5:0]) < NUM_REGS);
    assign ack_done    = (state == S_REQ) & vram.ack;

    // New op this strobe: data write, data read prefetch, or read-mode address set
    assign new_valid    = data_wr | data_rd | (addr_load & ~din[6]);
    assign new_cmd.op   = data_wr ? OP_WR : OP_RD;
    assign new_cmd.data = din;

    // Next address: increment on completion, control-port load overrides it
    always_comb begin
        addr_n = addr;
        if (ack_done)
            addr_n = addr + ADDR_BITS'(1);
        if (addr_load)
            addr_n = ADDR_BITS'({din[5:0], first_byte});
    end

    // FSM next state, issue decision and pending-slot control
    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        issue_cmd = new_cmd;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_valid) begin
                    issue   = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (vram.ack) begin
                    // Back-to-back: go straight to the next request, no IDLE bubble
                    if (pend_valid) begin
                        issue     = 1'b1;
                        issue_cmd = pend_cmd;
                        pend_clr  = ~new_valid;
                        pend_set  = new_valid;
                    end else if (new_valid) begin
                        issue = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (new_valid) begin
                    if (pend_valid) drop = 1'b1;
                    else            pend_set = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Address, two-byte latch, register file and read-ahead buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            toggle     <= 1'b0;
            first_byte <= 8'h00;
            reg_file   <= '0;
            rd_buf     <= 8'h00;
        end else begin
            addr <= addr_n;
            if (ctrl_wr)
                toggle <= ~toggle;
            else if (wr_stb | rd_stb)
                toggle <= 1'b0;
            if (ctrl_wr & ~toggle)
                first_byte <= din;
            if (reg_load)
                reg_file[din[RIW-1:0]] <= first_byte;
            if (ack_done & ~we_q)
                rd_buf <= vram.rdata;
            if (data_wr)
                rd_buf <= din;
        end
    end

    // Status flags: set pulses win over the clear that follows a status read
    always_ff @(posedge clk) begin
        if (reset) begin
            int_flag  <= 1'b0;
            coll_flag <= 1'b0;
            stat_rd_d <= 1'b0;
        end else begin
            stat_rd_d <= stat_rd;
            if (set_int)        int_flag <= 1'b1;
            else if (stat_rd_d) int_flag <= 1'b0;
            if (set_coll)        coll_flag <= 1'b1;
            else if (stat_rd_d)  coll_flag <= 1'b0;
        end
    end

    // Request registers (held stable until ack), pending slot and overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= (issue_cmd.op == OP_WR);
                addr_q  <= addr_n;
                wdata_q <= issue_cmd.data;
            end else if (ack_done) begin
                req_q <= 1'b0;
            end
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_cmd   <= new_cmd;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign vram.req   = req_q;
    assign vram.we    = we_q;
    assign vram.addr  = addr_q;
    assign vram.wdata = wdata_q;

    assign regs  = reg_file;
    assign busy  = (state != S_IDLE) | pend_valid;
    assign n_int = ~(int_flag & reg_file[1][5]);
    assign dout  = (port_sel == PORT_CTRL)
                 ? status_byte(int_flag, fifth_sprite, coll_flag, sprite5)
                 : rd_buf;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_vdp_cpu_port;

    logic        clk = 1'b0;
    logic        reset, clk_ena, io_wr, io_rd, port_sel;
    logic [7:0]  din, dout;
    logic [63:0] regs;
    logic        set_int, set_coll, fifth_sprite;
    logic [4:0]  sprite5;
    logic        n_int, busy, overflow;
    int          tests = 0;
    int          fails = 0;

    vdp_cpu_port_if #(.ADDR_BITS(14)) vram_bus ();

    vdp_cpu_port #(.ADDR_BITS(14), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .clk_ena(clk_ena), .io_wr(io_wr), .io_rd(io_rd),
        .port_sel(port_sel), .din(din), .dout(dout), .regs(regs),
        .set_int(set_int), .set_coll(set_coll), .fifth_sprite(fifth_sprite),
        .sprite5(sprite5), .n_int(n_int), .vram(vram_bus.master),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cpu_wr(input logic sel, input logic [7:0] d);
        clk_ena = 1'b1; io_wr = 1'b1; port_sel = sel; din = d;
        tick();
        io_wr = 1'b0; clk_ena = 1'b0;
    endtask

    task automatic cpu_rd(input logic sel, output logic [7:0] v);
        clk_ena = 1'b1; io_rd = 1'b1; port_sel = sel;
        #1 v = dout;
        @(posedge clk); #1;
        io_rd = 1'b0; clk_ena = 1'b0;
    endtask

    task automatic vram_ack(input logic [7:0] d);
        vram_bus.rdata = d; vram_bus.ack = 1'b1;
        tick();
        vram_bus.ack = 1'b0;
    endtask

    task automatic pulse_int();
        set_int = 1'b1; tick(); set_int = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        tests++; if (regs !== 64'h0) begin fails++; $display("FAIL rst_regs: got %h exp 0", regs); end
        tests++; if (vram_bus.req !== 1'b0 || vram_bus.we !== 1'b0) begin fails++; $display("FAIL rst_req: got req=%b we=%b exp 0 0", vram_bus.req, vram_bus.we); end
        tests++; if (busy !== 1'b0 || overflow !== 1'b0 || n_int !== 1'b1) begin fails++; $display("FAIL rst_flags: got busy=%b ovf=%b nint=%b exp 0 0 1", busy, overflow, n_int); end
        port_sel = 1'b0; #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rst_rdbuf: got %h exp 00", dout); end
        cpu_rd(1'b1, v);
        tests++; if (v !== 8'h1F) begin fails++; $display("FAIL rst_status: got %h exp 1F", v); end
    endtask

    task automatic test_write();
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b1, 8'h40);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_setup_busy: got %b exp 0", busy); end
        cpu_wr(1'b0, 8'hAA);
        tests++; if (vram_bus.req !== 1'b1 || vram_bus.we !== 1'b1 || vram_bus.addr !== 14'h0000 || vram_bus.wdata !== 8'hAA)
            begin fails++; $display("FAIL wr_req: got req=%b we=%b addr=%h wd=%h exp 1 1 0000 AA", vram_bus.req, vram_bus.we, vram_bus.addr, vram_bus.wdata); end
        port_sel = 1'b0; #1;
        tests++; if (dout !== 8'hAA) begin fails++; $display("FAIL wr_rdbuf: got %h exp AA", dout); end
        vram_ack(8'h00);
        tests++; if (vram_bus.req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL wr_done: got req=%b busy=%b exp 0 0", vram_bus.req, busy); end
        cpu_wr(1'b0, 8'h55);
        tests++; if (vram_bus.addr !== 14'h0001 || vram_bus.wdata !== 8'h55) begin fails++; $display("FAIL wr_incr: got addr=%h wd=%h exp 0001 55", vram_bus.addr, vram_bus.wdata); end
        vram_ack(8'h00);
    endtask

    task automatic test_read();
        logic [7:0] v;
        cpu_wr(1'b1, 8'h34);
        cpu_wr(1'b1, 8'h12);
        tests++; if (vram_bus.req !== 1'b1 || vram_bus.we !== 1'b0 || vram_bus.addr !== 14'h1234)
            begin fails++; $display("FAIL rd_req: got req=%b we=%b addr=%h exp 1 0 1234", vram_bus.req, vram_bus.we, vram_bus.addr); end
        vram_ack(8'h5C);
        cpu_rd(1'b0, v);
        tests++; if (v !== 8'h5C) begin fails++; $display("FAIL rd_data: got %h exp 5C", v); end
        tests++; if (vram_bus.req !== 1'b1 || vram_bus.we !== 1'b0 || vram_bus.addr !== 14'h1235)
            begin fails++; $display("FAIL rd_prefetch: got req=%b we=%b addr=%h exp 1 0 1235", vram_bus.req, vram_bus.we, vram_bus.addr); end
        vram_ack(8'h3C);
        cpu_rd(1'b0, v);
        tests++; if (v !== 8'h3C) begin fails++; $display("FAIL rd_data2: got %h exp 3C", v); end
        vram_ack(8'h00);
    endtask

    task automatic test_regs();
        cpu_wr(1'b1, 8'hF0);
        cpu_wr(1'b1, 8'h87);
        tests++; if (regs !== 64'hF000_0000_0000_0000) begin fails++; $display("FAIL reg7: got %h exp F000000000000000", regs); end
        cpu_wr(1'b1, 8'h11);
        cpu_wr(1'b1, 8'h88);
        tests++; if (regs !== 64'hF000_0000_0000_0000 || busy !== 1'b0) begin fails++; $display("FAIL reg_oor: got %h busy=%b exp F000000000000000 0", regs, busy); end
    endtask

    task automatic test_back_to_back();
        cpu_wr(1'b1, 8'hFF);
        cpu_wr(1'b1, 8'h7F);
        cpu_wr(1'b0, 8'h01);
        tests++; if (vram_bus.addr !== 14'h3FFF) begin fails++; $display("FAIL wrap_top: got %h exp 3FFF", vram_bus.addr); end
        vram_ack(8'h00);
        cpu_wr(1'b0, 8'h02);
        tests++; if (vram_bus.addr !== 14'h0000 || vram_bus.wdata !== 8'h02) begin fails++; $display("FAIL wrap_zero: got addr=%h wd=%h exp 0000 02", vram_bus.addr, vram_bus.wdata); end
        cpu_wr(1'b0, 8'h03);
        tests++; if (overflow !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL pend_fill: got ovf=%b busy=%b exp 0 1", overflow, busy); end
        cpu_wr(1'b0, 8'h04);
        tests++; if (overflow !== 1'b1 || vram_bus.addr !== 14'h0000 || vram_bus.wdata !== 8'h02)
            begin fails++; $display("FAIL ovf: got ovf=%b addr=%h wd=%h exp 1 0000 02", overflow, vram_bus.addr, vram_bus.wdata); end
        vram_ack(8'h00);
        tests++; if (vram_bus.req !== 1'b1 || vram_bus.addr !== 14'h0001 || vram_bus.wdata !== 8'h03)
            begin fails++; $display("FAIL b2b_issue: got req=%b addr=%h wd=%h exp 1 0001 03", vram_bus.req, vram_bus.addr, vram_bus.wdata); end
        vram_ack(8'h00);
        tests++; if (vram_bus.req !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1)
            begin fails++; $display("FAIL b2b_done: got req=%b busy=%b ovf=%b exp 0 0 1", vram_bus.req, busy, overflow); end
    endtask

    task automatic test_interrupt();
        logic [7:0] v;
        cpu_wr(1'b1, 8'h20);
        cpu_wr(1'b1, 8'h81);
        tests++; if (n_int !== 1'b1) begin fails++; $display("FAIL int_idle: got %b exp 1", n_int); end
        pulse_int();
        tests++; if (n_int !== 1'b0) begin fails++; $display("FAIL int_set: got %b exp 0", n_int); end
        cpu_rd(1'b1, v);
        tests++; if (v !== 8'h9F) begin fails++; $display("FAIL int_status: got %h exp 9F", v); end
        tests++; if (n_int !== 1'b0) begin fails++; $display("FAIL int_hold: got %b exp 0", n_int); end
        tick();
        tests++; if (n_int !== 1'b1) begin fails++; $display("FAIL int_clear: got %b exp 1", n_int); end
        pulse_int();
        cpu_rd(1'b1, v);
        set_int = 1'b1; tick(); set_int = 1'b0;
        tick();
        tests++; if (n_int !== 1'b0) begin fails++; $display("FAIL int_coincide: got %b exp 0", n_int); end
        cpu_rd(1'b1, v);
        tests++; if (v !== 8'h9F) begin fails++; $display("FAIL int_coincide_st: got %h exp 9F", v); end
        tick();
        tests++; if (n_int !== 1'b1) begin fails++; $display("FAIL int_clear2: got %b exp 1", n_int); end
    endtask

    task automatic test_collision();
        logic [7:0] v;
        fifth_sprite = 1'b1; sprite5 = 5'h0A;
        set_coll = 1'b1; tick(); set_coll = 1'b0;
        cpu_rd(1'b1, v);
        tests++; if (v !== 8'h6A) begin fails++; $display("FAIL coll_status: got %h exp 6A", v); end
        tick();
        fifth_sprite = 1'b0;
        cpu_rd(1'b1, v);
        tests++; if (v !== 8'h1F) begin fails++; $display("FAIL coll_clear: got %h exp 1F", v); end
    endtask

    task automatic test_toggle_reset();
        logic [7:0] v;
        cpu_wr(1'b1, 8'h12);
        cpu_rd(1'b1, v);
        cpu_wr(1'b1, 8'h34);
        cpu_wr(1'b1, 8'h40);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tog_busy: got %b exp 0", busy); end
        cpu_wr(1'b0, 8'h77);
        tests++; if (vram_bus.req !== 1'b1 || vram_bus.addr !== 14'h0034) begin fails++; $display("FAIL tog_addr: got req=%b addr=%h exp 1 0034", vram_bus.req, vram_bus.addr); end
        vram_ack(8'h00);
    endtask

    task automatic test_reset_mid();
        cpu_wr(1'b0, 8'h99);
        cpu_wr(1'b0, 8'h98);
        tests++; if (vram_bus.req !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre: got req=%b busy=%b exp 1 1", vram_bus.req, busy); end
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        tests++; if (vram_bus.req !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || regs !== 64'h0)
            begin fails++; $display("FAIL mid_rst: got req=%b busy=%b ovf=%b regs=%h exp 0 0 0 0", vram_bus.req, busy, overflow, regs); end
    endtask

    initial begin
        reset = 1'b1; clk_ena = 1'b0; io_wr = 1'b0; io_rd = 1'b0; port_sel = 1'b0; din = 8'h00;
        set_int = 1'b0; set_coll = 1'b0; fifth_sprite = 1'b0; sprite5 = 5'h00;
        vram_bus.ack = 1'b0; vram_bus.rdata = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_write();
        test_read();
        test_regs();
        test_back_to_back();
        test_interrupt();
        test_collision();
        test_toggle_reset();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
